// File: rtl/hit_window_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : hit_window_counter_if
// Brief    : Report channel (valid/ready + count/sat) of hit_window_counter.
// Revision : 1.0
// ============================================================================
interface hit_window_counter_if #(
  parameter int CNT_W = 8
) ();
  logic             report_valid;
  logic             report_ready;
  logic [CNT_W-1:0] report_count;
  logic             report_sat;

  modport master (
    output report_valid,
    output report_count,
    output report_sat,
    input  report_ready
  );

  modport slave (
    input  report_valid,
    input  report_count,
    input  report_sat,
    output report_ready
  );
endinterface
`default_nettype wire

// File: rtl/hit_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : hit_window_counter
// Brief    : Counts detector hits over back-to-back windows of WINDOW_LEN
//            cycles and reports each window's count over valid/ready.
//            Define HIT_INPUT_REG_EN to register hit_in before counting.
// Revision : 1.0
// ============================================================================
module hit_window_counter #(
  parameter int WINDOW_LEN = 16,
  parameter int CNT_W      = 8
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  hit_in,
  input  wire                  enable,
  hit_window_counter_if.master rpt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 window_busy
);

  localparam int                  c_WCNT_W    = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic [0:0]          r_state;
  logic [c_WCNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0]    r_acc;
  logic                r_sat;
  logic                r_report_valid;
  logic [CNT_W-1:0]    r_report_count;
  logic                r_report_sat;
  logic [CNT_W-1:0]    r_drop_cnt;

  logic                w_hit_s;
  logic                w_counting;
  logic                w_inc_at_max;
  logic [CNT_W-1:0]    w_acc_next;
  logic                w_sat_next;
  logic                w_win_end;
  logic                w_accept;
  logic                w_load;
  logic                w_drop;

`ifdef HIT_INPUT_REG_EN
  // Breaks the combinational path from the detector's Mealy output.
  logic r_hit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_q <= 1'b0;
    end else begin
      r_hit_q <= hit_in;
    end
  end

  assign w_hit_s = r_hit_q;
`else
  assign w_hit_s = hit_in;
`endif

  assign w_counting   = (r_state == S_COUNT) && enable;
  assign w_inc_at_max = w_hit_s && (r_acc == c_CNT_MAX);
  assign w_acc_next   = w_inc_at_max ? r_acc : (r_acc + CNT_W'(w_hit_s));
  assign w_sat_next   = r_sat | w_inc_at_max;
  assign w_win_end    = w_counting && (r_wcnt == c_WCNT_LAST);
  assign w_accept     = r_report_valid && rpt.report_ready;
  assign w_load       = w_win_end && (!r_report_valid || rpt.report_ready);
  assign w_drop       = w_win_end && !w_load;

  // Window sequencing; dropping enable discards the partial window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_COUNT;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end
        end
        S_COUNT: begin
          if (!enable) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end else if (w_win_end) begin
            r_wcnt  <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
          end else begin
            r_wcnt  <= r_wcnt + c_WCNT_W'(1);
            r_acc   <= w_acc_next;
            r_sat   <= w_sat_next;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // A new result may replace the pending one only on the edge it is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_report_valid <= 1'b0;
      r_report_count <= '0;
      r_report_sat   <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_load) begin
        r_report_valid <= 1'b1;
        r_report_count <= w_acc_next;
        r_report_sat   <= w_sat_next;
      end else if (w_accept) begin
        r_report_valid <= 1'b0;
      end
      if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
    end
  end

  assign rpt.report_valid = r_report_valid;
  assign rpt.report_count = r_report_count;
  assign rpt.report_sat   = r_report_sat;
  assign drop_cnt         = r_drop_cnt;
  assign window_busy      = (r_state == S_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_hit_window_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hit_window_counter
// Brief    : Scoreboard bench; a default DUT and a CNT_W=3 DUT share stimulus.
// Revision : 1.0
// ============================================================================
module tb_hit_window_counter;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       hit_in  = 1'b0;
  logic       enable  = 1'b0;
  logic       ready   = 1'b0;
  logic [7:0] drop_cnt;
  logic       window_busy;
  logic [2:0] drop_cnt_s;
  logic       window_busy_s;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int cnt;
    int sat;
    int cnt_s;
    int sat_s;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  hit_window_counter_if #(.CNT_W(8)) rif ();
  hit_window_counter_if #(.CNT_W(3)) rif_s ();

  assign rif.report_ready   = ready;
  assign rif_s.report_ready = ready;

  hit_window_counter #(.WINDOW_LEN(16), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .hit_in      (hit_in),
    .enable      (enable),
    .rpt         (rif),
    .drop_cnt    (drop_cnt),
    .window_busy (window_busy)
  );

  hit_window_counter #(.WINDOW_LEN(16), .CNT_W(3)) dut_s (
    .clk         (clk),
    .reset       (reset),
    .hit_in      (hit_in),
    .enable      (enable),
    .rpt         (rif_s),
    .drop_cnt    (drop_cnt_s),
    .window_busy (window_busy_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Expected report for n hits: the 3-bit DUT saturates at 7 once an 8th hit arrives.
  function automatic void push_exp(input int n);
    exp_t e;
    e.cnt   = n;
    e.sat   = 0;
    e.cnt_s = (n > 7) ? 7 : n;
    e.sat_s = (n > 7) ? 1 : 0;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_window(input logic [15:0] pat);
    for (int k = 0; k < 16; k++) begin
      tick();
      hit_in = pat[k];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(rif.report_valid), 0);
    chk({tag, "_count"}, int'(rif.report_count), 0);
    chk({tag, "_sat"},   int'(rif.report_sat), 0);
    chk({tag, "_drop"},  int'(drop_cnt), 0);
    chk({tag, "_busy"},  int'(window_busy), 0);
    chk({tag, "_valid_s"}, int'(rif_s.report_valid), 0);
    chk({tag, "_drop_s"},  int'(drop_cnt_s), 0);
  endtask

  // Monitor: every accepted report is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && rif.report_valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_report: got count %0d, required no report", rif.report_count);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rpt_count",   int'(rif.report_count), mon_e.cnt);
        chk("rpt_sat",     int'(rif.report_sat), mon_e.sat);
        chk("rpt_valid_s", int'(rif_s.report_valid), 1);
        chk("rpt_count_s", int'(rif_s.report_count), mon_e.cnt_s);
        chk("rpt_sat_s",   int'(rif_s.report_sat), mon_e.sat_s);
      end
    end
  end

  initial begin
    tick();
    tick();
    chk_all_zero("reset");

    // Hits at window cycles 3, 7, 15 with the reader always ready.
`ifdef HIT_INPUT_REG_EN
    push_exp(2);
    push_exp(1);
`else
    push_exp(3);
    push_exp(0);
`endif
    reset  = 1'b0;
    enable = 1'b1;
    ready  = 1'b1;
    chk("s1_busy_enable_cycle", int'(window_busy), 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 0) chk("s1_busy_rise", int'(window_busy), 1);
      hit_in = (k == 3 || k == 7 || k == 15);
    end
    tick();
    hit_in = 1'b0;
    chk("s1_valid_rise", int'(rif.report_valid), 1);
    tick();
    chk("s1_valid_pulse", int'(rif.report_valid), 0);
    for (int k = 2; k < 16; k++) tick();
    tick();
    enable = 1'b0;
    tick();
    chk("s1_busy_fall", int'(window_busy), 0);

    // Full window of hits saturates the 3-bit DUT; next window restarts at 0.
`ifdef HIT_INPUT_REG_EN
    push_exp(15);
    push_exp(1);
`else
    push_exp(16);
    push_exp(0);
`endif
    tick();
    enable = 1'b1;
    run_window(16'hFFFF);
    run_window(16'h0000);
    tick();
    enable = 1'b0;
    hit_in = 1'b0;
    tick();

    // Reader stalled for three windows of 2 hits: first held, two dropped.
    push_exp(2);
    tick();
    enable = 1'b1;
    ready  = 1'b0;
    run_window(16'h0024);
    run_window(16'h0024);
    run_window(16'h0024);
    tick();
    chk("s3_valid_held", int'(rif.report_valid), 1);
    chk("s3_count_held", int'(rif.report_count), 2);
    chk("s3_drop_cnt",   int'(drop_cnt), 2);
    chk("s3_drop_cnt_s", int'(drop_cnt_s), 2);
    enable = 1'b0;
    ready  = 1'b1;
    tick();
    chk("s3_valid_clear", int'(rif.report_valid), 0);
    chk("s3_count_hold",  int'(rif.report_count), 2);
    chk("s3_busy",        int'(window_busy), 0);

    // Enable drops at window cycle 9 after 5 hits; that partial window is lost.
    push_exp(2);
    tick();
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      hit_in = (k % 2 == 0);
    end
    tick();
    enable = 1'b0;
    hit_in = 1'b0;
    tick();
    chk("s4_busy_off",  int'(window_busy), 0);
    chk("s4_no_report", int'(rif.report_valid), 0);
    enable = 1'b1;
    run_window(16'h0402);
    tick();
    enable = 1'b0;
    hit_in = 1'b0;
    tick();

    // Reset at window cycle 6 with a report pending and one drop recorded.
    reset = 1'b1;
    tick();
    reset  = 1'b0;
    enable = 1'b1;
    ready  = 1'b0;
    run_window(16'h0010);
    run_window(16'h0000);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 0) begin
        chk("s5_pre_valid", int'(rif.report_valid), 1);
        chk("s5_pre_drop",  int'(drop_cnt), 1);
      end
      if (k == 6) reset = 1'b1;
    end
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    chk_all_zero("s5");
    tick();
    chk("s5_idle", int'(window_busy), 0);

    // Single hit in the last cycle of a window.
`ifdef HIT_INPUT_REG_EN
    push_exp(0);
    push_exp(1);
`else
    push_exp(1);
    push_exp(0);
`endif
    ready  = 1'b1;
    enable = 1'b1;
    run_window(16'h8000);
    run_window(16'h0000);
    tick();
    enable = 1'b0;
    hit_in = 1'b0;
    tick();
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
